// File: rtl/u_bam8_mac_acc_pkg.sv
// Shared types and default sizing for the BAM8 multiply-accumulate stage.
// State encoding for the frame FSM plus default LEN/ACC_W/CNT_W.
package bam_acc_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int LEN_DEF   = 256;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 9;

endpackage

// File: rtl/u_bam8_mac_acc_if.sv
// Operand-in / frame-result-out handshake bundle for the BAM8 MAC stage.
// master = producer/consumer side, slave = the MAC stage.
interface u_bam8_mac_acc_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_ovf
    );
endinterface

// File: rtl/h_u_csabam8_rca_h2_v9.sv
// 8x8 unsigned broken-array multiplier: partial-product rows below 2 and columns below 9 are dropped.
// Purely combinational; the surviving array is resolved exactly by the final ripple adder.
module h_u_csabam8_rca_h2_v9 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] h_u_csabam8_rca_h2_v9_out
);
    always_comb begin
        h_u_csabam8_rca_h2_v9_out = '0;
        for (int j = 2; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                if (i + j >= 9) begin
                    h_u_csabam8_rca_h2_v9_out = h_u_csabam8_rca_h2_v9_out
                        + ({15'd0, a[i] & b[j]} << (i + j));
                end
            end
        end
    end
endmodule

// File: rtl/u_bam8_mac_acc_pipe.sv
// Two-stage operand/product pipeline around the approximate multiplier core.
// Latency 2 edges from accept to registered product; no backpressure (always advances).
module u_bam8_mac_pipe
    import bam_acc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vld,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    input  logic        i_last,
    output logic        o_p_vld,
    output logic [15:0] o_p_dat,
    output logic        o_p_last
);
    logic        r_s1_v;
    logic        r_s1_last;
    logic [7:0]  r_s1_a;
    logic [7:0]  r_s1_b;
    logic        r_p_v;
    logic        r_p_last;
    logic [15:0] r_p_q;
    logic [15:0] w_prod;

    h_u_csabam8_rca_h2_v9 u_core (
        .a                         (r_s1_a),
        .b                         (r_s1_b),
        .h_u_csabam8_rca_h2_v9_out (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_p_v     <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_q     <= '0;
        end else begin
            r_s1_v    <= i_vld;
            r_s1_last <= i_vld & i_last;
            if (i_vld) begin
                r_s1_a <= i_a;
                r_s1_b <= i_b;
            end
            r_p_v    <= r_s1_v;
            r_p_last <= r_s1_v & r_s1_last;
            if (r_s1_v) begin
                r_p_q <= w_prod;
            end
        end
    end

    assign o_p_vld  = r_p_v;
    assign o_p_dat  = r_p_q;
    assign o_p_last = r_p_last;
endmodule

// File: rtl/u_bam8_mac_acc.sv
// Frame accumulator of approximate 8x8 products; result registered 3 edges after the closing accept.
// Input stalls from the closing beat until the frame result is taken by the consumer.
module u_bam8_mac_acc
    import bam_acc_pkg::*;
#(
    parameter int LEN   = LEN_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    u_bam8_mac_acc_if.slave     bus
);
    state_t           r_state;
    logic             r_in_rdy;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_out_vld;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_ovf;

    logic             w_accept;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_close;
    logic             w_p_vld;
    logic [15:0]      w_p_dat;
    logic             w_p_last;
    logic [ACC_W:0]   w_sum_ext;

    assign w_accept  = bus.in_valid & r_in_rdy;
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_close   = bus.in_last | (w_cnt_inc == (CNT_W+1)'(LEN));
    // Top bit of the extended sum is the carry out of the accumulator.
    assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, w_p_dat};

    u_bam8_mac_pipe u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vld    (w_accept),
        .i_a      (bus.in_a),
        .i_b      (bus.in_b),
        .i_last   (w_close),
        .o_p_vld  (w_p_vld),
        .o_p_dat  (w_p_dat),
        .o_p_last (w_p_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACC;
            r_in_rdy  <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_sum <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    r_in_rdy <= 1'b1;
                    if (w_accept) begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                        if (w_close) begin
                            r_state  <= ST_FLUSH;
                            r_in_rdy <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: r_in_rdy <= 1'b0;
                ST_HOLD: begin
                    r_in_rdy <= 1'b0;
                    if (r_out_vld && bus.out_ready) begin
                        r_out_vld <= 1'b0;
                        r_state   <= ST_ACC;
                        r_in_rdy  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_ACC;
                    r_in_rdy <= 1'b0;
                end
            endcase

            // Product drain runs independently of the FSM; the closing product retires the frame.
            if (w_p_vld) begin
                if (w_p_last) begin
                    r_out_sum <= w_sum_ext[ACC_W-1:0];
                    r_out_cnt <= r_cnt;
                    r_out_ovf <= r_ovf | w_sum_ext[ACC_W];
                    r_out_vld <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                    r_state   <= ST_HOLD;
                end else begin
                    r_acc <= w_sum_ext[ACC_W-1:0];
                    r_ovf <= r_ovf | w_sum_ext[ACC_W];
                end
            end
        end
    end

    assign bus.in_ready  = r_in_rdy;
    assign bus.out_valid = r_out_vld;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_cnt   = r_out_cnt;
    assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_u_bam8_mac_acc.sv
// Bench for u_bam8_mac_acc: 24-bit and 16-bit accumulator instances share one stimulus stream
// and are compared every cycle against a frame-level arithmetic model.
module tb_u_bam8_mac_acc;

    localparam int LEN = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tb_valid;
    logic [7:0] tb_a;
    logic [7:0] tb_b;
    logic       tb_last;
    logic       tb_out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    u_bam8_mac_acc_if #(.ACC_W(24), .CNT_W(9)) if24 ();
    u_bam8_mac_acc_if #(.ACC_W(16), .CNT_W(9)) if16 ();

    assign if24.in_valid  = tb_valid;
    assign if24.in_a      = tb_a;
    assign if24.in_b      = tb_b;
    assign if24.in_last   = tb_last;
    assign if24.out_ready = tb_out_ready;
    assign if16.in_valid  = tb_valid;
    assign if16.in_a      = tb_a;
    assign if16.in_b      = tb_b;
    assign if16.in_last   = tb_last;
    assign if16.out_ready = tb_out_ready;

    u_bam8_mac_acc #(.LEN(LEN), .ACC_W(24), .CNT_W(9)) dut24 (.clk(clk), .rst_n(rst_n), .bus(if24));
    u_bam8_mac_acc #(.LEN(LEN), .ACC_W(16), .CNT_W(9)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product minus the partial products the broken array discards.
    function automatic longint core_m(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if ((j < 2 || i + j < 9) && a[i] && b[j])
                    p -= longint'(1) << (i + j);
        return p;
    endfunction

    typedef struct {
        longint sum;
        int     cnt;
    } frame_t;

    frame_t q[$];
    longint cur_sum;
    int     cur_cnt;
    bit     busy;
    bit     rdy_exp;
    bit     vld_exp;
    int     pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur_sum = 0;
            cur_cnt = 0;
            busy    = 0;
            rdy_exp = 0;
            vld_exp = 0;
            pend    = 0;
        end else begin
            if (vld_exp && tb_out_ready) begin
                void'(q.pop_front());
                vld_exp = 0;
                busy    = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) vld_exp = 1;
            end
            if (tb_valid && if24.in_ready) begin
                cur_sum += core_m(int'(tb_a), int'(tb_b));
                cur_cnt++;
                if (tb_last || cur_cnt == LEN) begin
                    q.push_back('{sum: cur_sum, cnt: cur_cnt});
                    cur_sum = 0;
                    cur_cnt = 0;
                    busy    = 1;
                    pend    = 2;
                end
            end
            rdy_exp = !busy;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready24", longint'(if24.in_ready), longint'(rdy_exp));
            chk("in_ready16", longint'(if16.in_ready), longint'(rdy_exp));
            chk("out_valid24", longint'(if24.out_valid), longint'(vld_exp));
            chk("out_valid16", longint'(if16.out_valid), longint'(vld_exp));
            if (vld_exp && q.size() > 0) begin
                chk("sum24", longint'(if24.out_sum), q[0].sum % (longint'(1) << 24));
                chk("cnt24", longint'(if24.out_cnt), longint'(q[0].cnt));
                chk("ovf24", longint'(if24.out_ovf), longint'(q[0].sum >= (longint'(1) << 24)));
                chk("sum16", longint'(if16.out_sum), q[0].sum % (longint'(1) << 16));
                chk("cnt16", longint'(if16.out_cnt), longint'(q[0].cnt));
                chk("ovf16", longint'(if16.out_ovf), longint'(q[0].sum >= (longint'(1) << 16)));
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        tb_a = a; tb_b = b; tb_last = last; tb_valid = 1'b1;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (if24.in_ready) break;
            n++;
        end
        if (n == 1000) chk("send_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
        tb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        tb_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!if24.out_valid && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid_timeout", longint'(if24.out_valid), 1);
    endtask

    task automatic take();
        tb_out_ready = 1'b1;
        @(posedge clk);
        #1;
        tb_out_ready = 1'b0;
    endtask

    initial begin
        int len;
        rst_n = 1'b0; tb_valid = 1'b1; tb_a = 8'd7; tb_b = 8'd9; tb_last = 1'b0; tb_out_ready = 1'b0;

        chk("model_255x255", core_m(255, 255), 61440);
        chk("model_128x128", core_m(128, 128), 16384);
        chk("model_1x1", core_m(1, 1), 0);

        // Reset with in_valid asserted
        #1;
        chk("rst_in_ready", longint'(if24.in_ready), 0);
        chk("rst_out_valid", longint'(if24.out_valid), 0);
        chk("rst_out_sum", longint'(if24.out_sum), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", longint'(if24.in_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_post", longint'(if24.in_ready), 1);
        tb_valid = 1'b0;
        idle(2);

        // Zero-product frame and latency from the closing accept
        send(8'd0, 8'd0, 1'b0);
        send(8'd0, 8'd255, 1'b0);
        send(8'd255, 8'd0, 1'b1);
        chk("lat_e1", longint'(if24.out_valid), 0);
        @(posedge clk); #1;
        chk("lat_e2", longint'(if24.out_valid), 0);
        @(posedge clk); #1;
        chk("lat_e3", longint'(if24.out_valid), 1);
        chk("f0_sum", longint'(if24.out_sum), 0);
        chk("f0_cnt", longint'(if24.out_cnt), 3);
        chk("f0_ovf", longint'(if24.out_ovf), 0);
        take();

        // Full-length frame without in_last
        for (int k = 0; k < LEN; k++) send(8'd255, 8'd255, 1'b0);
        chk("len_in_ready_low", longint'(if24.in_ready), 0);
        wait_out();
        chk("len_sum24", longint'(if24.out_sum), 64'hF00000);
        chk("len_cnt24", longint'(if24.out_cnt), 256);
        chk("len_ovf24", longint'(if24.out_ovf), 0);
        chk("len_sum16", longint'(if16.out_sum), 0);
        chk("len_ovf16", longint'(if16.out_ovf), 1);
        take();

        // in_last coincides with beat LEN
        for (int k = 0; k < LEN; k++) send(8'd255, 8'd255, k == LEN - 1);
        wait_out();
        chk("lenlast_cnt", longint'(if24.out_cnt), 256);
        take();
        idle(3);
        chk("single_close", longint'(if24.out_valid), 0);

        // Random frames with bubbles and a stalled consumer
        for (int f = 0; f < 6; f++) begin
            len = int'($urandom_range(1, 24));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
                send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), k == len - 1);
            end
            wait_out();
            tb_valid = 1'b1; tb_last = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            tb_valid = 1'b0;
            chk("hold_valid", longint'(if24.out_valid), 1);
            take();
        end

        // Reset mid-frame discards everything
        for (int k = 0; k < 5; k++) send(8'($urandom_range(1, 255)), 8'd200, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", longint'(if24.in_ready), 0);
        chk("mid_rst_out_valid", longint'(if24.out_valid), 0);
        chk("mid_rst_out_sum", longint'(if24.out_sum), 0);
        chk("mid_rst_out_cnt", longint'(if24.out_cnt), 0);
        chk("mid_rst_out_ovf", longint'(if16.out_ovf), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'd128, 8'd128, 1'b0);
        send(8'd1, 8'd1, 1'b1);
        wait_out();
        chk("post_rst_sum", longint'(if24.out_sum), 16384);
        chk("post_rst_cnt", longint'(if24.out_cnt), 2);
        take();
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
